fifo_ext: RTL

FIFO_EXT -- requirements
Module: fifo_ext

---
 rtl/fifo_ext.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ext
// Description : Synchronous single-clock FIFO with registered read data,
//               registered occupancy flags, almost-full threshold, synchronous
//               flush and optional sticky overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       data word width in bits (>= 1)
//   LOG2_DEPTH  storage depth is 2**LOG2_DEPTH words (>= 2)
//   AF_MARGIN   almostfull asserts when count >= DEPTH - AF_MARGIN
//               (1 <= AF_MARGIN < DEPTH)
// Ports
//   clk         clock, rising edge only
//   reset       synchronous active-high reset, highest priority
//   clear       synchronous flush; we/re of the same cycle are ignored
//   we / wdata  write request and data (accepted iff we && !full)
//   re          read request (accepted iff re && !empty)
//   rdata       registered read data, holds when rvalid = 0
//   rvalid      high in the cycle after an accepted read
//   empty       count == 0        (registered)
//   full        count == DEPTH    (registered)
//   almostfull  count >= DEPTH - AF_MARGIN (registered)
//   count       occupancy, 0..DEPTH
//   overflow    sticky write-while-full flag   (FIFO_ERR_FLAGS_EN only)
//   underflow   sticky read-while-empty flag   (FIFO_ERR_FLAGS_EN only)
// Configuration
//   FIFO_ERR_FLAGS_EN  when defined, overflow/underflow flag logic is built;
//                      otherwise both outputs are tied to 0.
// ============================================================================
module fifo_ext #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 5,
  parameter int AF_MARGIN  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  full,
  output logic                  almostfull,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  c_DEPTH     = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] c_CNT_ZERO  = '0;
  localparam logic [LOG2_DEPTH:0] c_CNT_ONE   = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH:0] c_CNT_FULL  = (LOG2_DEPTH+1)'(c_DEPTH);
  localparam logic [LOG2_DEPTH:0] c_AF_THRESH = (LOG2_DEPTH+1)'(c_DEPTH - AF_MARGIN);
  localparam logic [LOG2_DEPTH-1:0] c_PTR_ONE = (LOG2_DEPTH)'(1);

  // Storage and state
  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH-1:0] r_rd_ptr;
  logic [LOG2_DEPTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almostfull;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_rvalid;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [LOG2_DEPTH:0]   w_count_nxt;

  // Acceptance is decided on the registered flags only. Reset and clear
  // suppress both so that neither memory nor pointers move in that cycle.
  assign w_wr_acc = we && !r_full  && !reset && !clear;
  assign w_rd_acc = re && !r_empty && !reset && !clear;

  // Occupancy after this edge; a simultaneous accepted read and write
  // leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Memory array carries no reset; stale contents are unreachable because
  // the pointers and count are reset together.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and flags. Flags are computed from the next count so
  // they are valid in the same cycle as the new count value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= c_CNT_ZERO;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_almostfull <= 1'b0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= c_CNT_ZERO;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_almostfull <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count      <= w_count_nxt;
      r_empty      <= (w_count_nxt == c_CNT_ZERO);
      r_full       <= (w_count_nxt == c_CNT_FULL);
      r_almostfull <= (w_count_nxt >= c_AF_THRESH);
    end
  end

  // Read data path. The read and write pointers coincide only when the FIFO
  // is empty or full, and in those states at most one of the two operations
  // can be accepted, so no read-during-write bypass is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: an attempted write while full or read while empty
  // sets the flag; only reset or clear release it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (we && r_full) begin
        r_overflow <= 1'b1;
      end
      if (re && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rdata      = r_rdata;
  assign rvalid     = r_rvalid;
  assign empty      = r_empty;
  assign full       = r_full;
  assign almostfull = r_almostfull;
  assign count      = r_count;

endmodule
`default_nettype wire
